sim_monitor: RTL and testbench

SIM_MONITOR -- requirements
Module: sim_monitor

---
 rtl/sim_monitor_if.sv | 14 +
 rtl/sim_monitor.sv | 123 ++++++++++++
 tb/tb_sim_monitor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sim_monitor_if.sv
// Record stream from sim_monitor to its consumer: valid/ready handshake
// carrying one phase transition per beat.
interface sim_monitor_if #(
  parameter int W = 32
);
  logic         rec_valid;
  logic         rec_ready;
  logic [1:0]   rec_from;
  logic [1:0]   rec_to;
  logic [W-1:0] rec_cycle;

  modport master (output rec_valid, rec_from, rec_to, rec_cycle, input rec_ready);
  modport slave  (input rec_valid, rec_from, rec_to, rec_cycle, output rec_ready);
endinterface

// File: rtl/sim_monitor.sv
// Watches a simulator's phase and cycle count, queues phase-transition records
// in a small FIFO and raises sticky flags for illegal phase or count behaviour.
//
// state    | meaning
// UNPRIMED | first cycle after reset: capture phase/count, no checks
// WATCH    | checking every cycle, COMPLETED not yet recorded
// FINISHED | COMPLETED recorded; keeps checking until reset
module sim_monitor #(
  parameter int MAX_CYCLE_WIDTH = 32,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 state,
  input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  sim_monitor_if.master              rec,
  output logic                       illegal,
  output logic                       cycle_err,
  output logic                       overflow,
  output logic                       done
);
  localparam int W  = MAX_CYCLE_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [W-1:0]  ALL_ONES = '1;
  localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {UNPRIMED, WATCH, FINISHED} mon_t;

  mon_t            fsm, fsm_nxt;
  logic [1:0]      prev_state;
  logic [W-1:0]    prev_cycle;
  logic            push, legal, cycle_ok, pop, full, accept, valid;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [1:0]      mem_from  [DEPTH];
  logic [1:0]      mem_to    [DEPTH];
  logic [W-1:0]    mem_cycle [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm <= UNPRIMED;
    else          fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      UNPRIMED: fsm_nxt = WATCH;
      WATCH:    if (push && state == 2'b11) fsm_nxt = FINISHED;
      FINISHED: fsm_nxt = FINISHED;
      default:  fsm_nxt = UNPRIMED;
    endcase
  end

  always_comb begin
    push  = (fsm != UNPRIMED) && (state != prev_state);
    legal = 1'b0;
    case ({prev_state, state})
      4'b0001, 4'b0110, 4'b1011: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    // The simulator saturates at all-ones, so a wrap to zero counts as an error.
    cycle_ok = (prev_cycle != ALL_ONES && current_cycle == prev_cycle + ONE) ||
               (prev_cycle == ALL_ONES && current_cycle == ALL_ONES);
    valid  = (count != '0);
    full   = (count == FULL_CNT);
    pop    = valid && rec.rec_ready;
    accept = push && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state <= 2'b00;
      prev_cycle <= '0;
      illegal    <= 1'b0;
      cycle_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_state <= state;
      prev_cycle <= current_cycle;
      if (fsm != UNPRIMED) begin
        if (push && !legal)        illegal   <= 1'b1;
        if (!cycle_ok)             cycle_err <= 1'b1;
        if (push && full && !pop)  overflow  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every read is gated by a non-zero count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_from[wr_ptr]  <= prev_state;
      mem_to[wr_ptr]    <= state;
      mem_cycle[wr_ptr] <= current_cycle;
    end
  end

  always_comb begin
    rec.rec_valid = valid;
    rec.rec_from  = valid ? mem_from[rd_ptr]  : 2'b00;
    rec.rec_to    = valid ? mem_to[rd_ptr]    : 2'b00;
    rec.rec_cycle = valid ? mem_cycle[rd_ptr] : '0;
    done          = (fsm == FINISHED) && !valid;
  end
endmodule

// File: tb/tb_sim_monitor.sv
// Bench for sim_monitor: directed phase/count sequences, a transaction-level
// model compared every cycle, and literal checks on the model's popped records.
module tb_sim_monitor;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] MAXC = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [1:0]   f;
    logic [1:0]   t;
    logic [W-1:0] c;
  } rec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   state = 2'b00;
  logic [W-1:0] current_cycle = '0;
  logic         illegal, cycle_err, overflow, done;

  int total = 0;
  int bad   = 0;

  sim_monitor_if #(.W(W)) rif ();

  sim_monitor #(.MAX_CYCLE_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .state         (state),
    .current_cycle (current_cycle),
    .rec           (rif.master),
    .illegal       (illegal),
    .cycle_err     (cycle_err),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Model: queue of records plus flags, updated per rising edge from the rules.
  rec_t   m_q[$];
  rec_t   popped[$];
  bit     m_primed = 0, m_fin = 0, m_ill = 0, m_cerr = 0, m_ovf = 0;
  logic [1:0]   m_ps = 2'b00;
  logic [W-1:0] m_pc = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_primed = 0; m_fin = 0; m_ill = 0; m_cerr = 0; m_ovf = 0;
    end else begin
      bit   do_pop, do_push;
      int   n;
      rec_t r;
      n       = m_q.size();
      do_pop  = (n != 0) && rif.rec_ready;
      do_push = 0;
      r       = '0;
      if (!m_primed) begin
        m_primed = 1;
      end else begin
        if (state != m_ps) begin
          r = '{f: m_ps, t: state, c: current_cycle};
          do_push = 1;
          if (int'(state) != int'(m_ps) + 1) m_ill = 1;
          if (state == 2'b11) m_fin = 1;
        end
        if (!((longint'(current_cycle) == longint'(m_pc) + 1) ||
              (current_cycle == MAXC && m_pc == MAXC)))
          m_cerr = 1;
      end
      m_ps = state;
      m_pc = current_cycle;
      if (do_pop) popped.push_back(m_q.pop_front());
      if (do_push) begin
        if (n < DEPTH || do_pop) m_q.push_back(r);
        else m_ovf = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    chk("rec_valid", 64'(rif.rec_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("rec_from",  64'(rif.rec_from),  64'(m_q[0].f));
      chk("rec_to",    64'(rif.rec_to),    64'(m_q[0].t));
      chk("rec_cycle", 64'(rif.rec_cycle), 64'(m_q[0].c));
    end
    chk("illegal",   64'(illegal),   64'(m_ill));
    chk("cycle_err", 64'(cycle_err), 64'(m_cerr));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("done",      64'(done),      64'(m_fin && m_q.size() == 0));
  end

  task automatic tick(input logic [1:0] s, input logic [W-1:0] c, input logic rdy);
    state = s;
    current_cycle = c;
    rif.rec_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    popped.delete();
    reset_n = 1'b1;
  endtask

  task automatic exp_rec(input string nm, input int idx,
                         input logic [1:0] f, input logic [1:0] t, input logic [W-1:0] c);
    rec_t e;
    e = '{f: f, t: t, c: c};
    if (idx < popped.size()) chk(nm, 64'(popped[idx]), 64'(e));
    else chk({nm, "_missing"}, 64'(popped.size()), 64'(idx + 1));
  endtask

  initial begin
    rif.rec_ready = 1'b1;
    @(negedge clk);
    // Reset state, checked literally.
    chk("reset_valid", 64'(rif.rec_valid), 64'd0);
    chk("reset_done",  64'(done), 64'd0);

    // Normal run 00 -> 01 -> 10 -> 11.
    do_reset();
    tick(2'b00, 0, 1);
    tick(2'b01, 1, 1);
    tick(2'b10, 2, 1);
    tick(2'b11, MAXC, 1);
    for (int i = 0; i < 4; i++) tick(2'b11, MAXC, 1);
    exp_rec("norm_r0", 0, 2'b00, 2'b01, 1);
    exp_rec("norm_r1", 1, 2'b01, 2'b10, 2);
    exp_rec("norm_r2", 2, 2'b10, 2'b11, MAXC);
    chk("norm_illegal", 64'(illegal), 64'd0);
    chk("norm_done",    64'(done), 64'd1);

    // Illegal jump 01 -> 11.
    do_reset();
    tick(2'b00, 3, 1);
    tick(2'b01, 4, 1);
    tick(2'b11, 5, 1);
    for (int i = 0; i < 3; i++) tick(2'b11, 32'(6 + i), 1);
    exp_rec("ill_r1", 1, 2'b01, 2'b11, 5);
    chk("ill_flag",  64'(illegal), 64'd1);
    chk("ill_cerr",  64'(cycle_err), 64'd0);
    chk("ill_done",  64'(done), 64'd1);

    // Overflow: five changes with the consumer stalled.
    do_reset();
    tick(2'b00, 10, 0);
    tick(2'b01, 11, 0);
    tick(2'b10, 12, 0);
    tick(2'b11, 13, 0);
    tick(2'b00, 14, 0);
    tick(2'b01, 15, 0);
    tick(2'b01, 16, 0);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_head",  64'(rif.rec_cycle), 64'd11);
    for (int i = 0; i < 6; i++) tick(2'b01, 32'(17 + i), 1);
    exp_rec("ovf_r0", 0, 2'b00, 2'b01, 11);
    exp_rec("ovf_r1", 1, 2'b01, 2'b10, 12);
    exp_rec("ovf_r2", 2, 2'b10, 2'b11, 13);
    exp_rec("ovf_r3", 3, 2'b11, 2'b00, 14);
    chk("ovf_count", 64'(popped.size()), 64'd4);

    // Cycle count: skip, saturation hold, wrap.
    do_reset();
    tick(2'b00, 5, 1);
    tick(2'b00, 6, 1);
    tick(2'b00, 7, 1);
    chk("cnt_ok", 64'(cycle_err), 64'd0);
    tick(2'b00, 9, 1);
    chk("cnt_skip", 64'(cycle_err), 64'd1);
    do_reset();
    tick(2'b10, MAXC - 1, 1);
    tick(2'b10, MAXC, 1);
    for (int i = 0; i < 10; i++) tick(2'b10, MAXC, 1);
    chk("cnt_sat", 64'(cycle_err), 64'd0);
    tick(2'b10, 0, 1);
    chk("cnt_wrap", 64'(cycle_err), 64'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    tick(2'b00, 20, 0);
    tick(2'b01, 21, 0);
    tick(2'b10, 22, 0);
    tick(2'b11, 23, 0);
    tick(2'b00, 24, 0);
    tick(2'b00, 25, 0);
    tick(2'b01, 26, 1);
    tick(2'b01, 27, 0);
    chk("pp_occ", 64'(m_q.size()), 64'd4);
    chk("pp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) tick(2'b01, 32'(28 + i), 1);
    exp_rec("pp_r0", 0, 2'b00, 2'b01, 21);
    exp_rec("pp_r3", 3, 2'b11, 2'b00, 24);
    exp_rec("pp_r4", 4, 2'b00, 2'b01, 26);

    // Reset mid-operation with records queued and illegal set.
    do_reset();
    tick(2'b00, 0, 0);
    tick(2'b01, 1, 0);
    tick(2'b11, 2, 0);
    tick(2'b11, 3, 0);
    chk("mid_pre_ill", 64'(illegal), 64'd1);
    reset_n = 1'b0;
    #2;
    chk("mid_valid", 64'(rif.rec_valid), 64'd0);
    chk("mid_rec",   64'({rif.rec_from, rif.rec_to, rif.rec_cycle}), 64'd0);
    chk("mid_flags", 64'({illegal, cycle_err, overflow, done}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2'b10, 50, 1);
    chk("mid_prime_valid", 64'(rif.rec_valid), 64'd0);
    tick(2'b10, 51, 1);
    chk("mid_after_valid", 64'(rif.rec_valid), 64'd0);
    chk("mid_after_flags", 64'({illegal, cycle_err, overflow}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
